// File: rtl/pll_dyn_ctrl.sv
// rtl/pll_dyn_ctrl.sv - EHXPLLL dynamic phase-shift sequencer with filtered lock and sticky errors
module pll_dyn_ctrl #(
    parameter int CHANNELS     = 4,
    parameter int STEP_WIDTH   = 8,
    parameter int LOCK_FILTER  = 1024,
    parameter int PULSE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  pll_lock_in,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_channel,
    input  logic                  cmd_dir,
    input  logic [STEP_WIDTH-1:0] cmd_steps,
    output logic [1:0]            phasesel,
    output logic                  phasedir,
    output logic                  phasestep,
    output logic                  phaseloadreg,
    output logic                  locked_stable,
    output logic                  busy,
    output logic                  err_lock_lost,
    output logic                  err_bad_channel,
    input  logic                  err_clear
);
    localparam int LW = $clog2(LOCK_FILTER + 1);
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_FILTER);
    localparam logic [PW-1:0] PHASE_LAST = PW'(PULSE_CYCLES - 1);
    localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STEP_LO, S_STEP_HI, S_SETTLE} state_t;

    logic                  r_sync1;
    logic                  r_sync2;
    logic [LW-1:0]         r_lock_cnt;
    state_t                r_state;
    logic [PW-1:0]         r_pcnt;
    logic [STEP_WIDTH-1:0] r_remain;
    logic [1:0]            r_sel;
    logic                  r_dir;
    logic                  r_step;
    logic                  r_busy;
    logic                  r_err_lock;
    logic                  r_err_bad;

    logic                  w_locked;
    logic                  w_accept;
    logic                  w_bad_chan;
    logic                  w_phase_done;
    logic                  w_lock_lost;
    logic [31:0]           w_chan_ext;

    assign w_locked     = (r_lock_cnt == LOCK_MAX);
    assign w_accept     = cmd_valid & cmd_ready;
    assign w_chan_ext   = {30'd0, cmd_channel};
    assign w_bad_chan   = (w_chan_ext >= 32'(CHANNELS));
    assign w_phase_done = (r_pcnt == PHASE_LAST);
    assign w_lock_lost  = (r_state != S_IDLE) && !w_locked;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_lock_cnt <= '0;
        end else begin
            r_sync1 <= pll_lock_in;
            r_sync2 <= r_sync1;
            if (!r_sync2) begin
                r_lock_cnt <= '0;
            end else if (!w_locked) begin
                r_lock_cnt <= r_lock_cnt + 1'b1;
            end
        end
    end

    // phasestep and busy are registered with the state so the PLL never sees decode glitches
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_pcnt   <= '0;
            r_remain <= '0;
            r_sel    <= 2'd0;
            r_dir    <= 1'b1;
            r_step   <= 1'b1;
            r_busy   <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_pcnt <= '0;
            if (w_accept) begin
                r_sel    <= cmd_channel;
                r_dir    <= cmd_dir;
                r_remain <= cmd_steps;
                if (!w_bad_chan && (cmd_steps != '0)) begin
                    r_state <= S_SETUP;
                    r_busy  <= 1'b1;
                end
            end
        end else if (w_lock_lost) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_step   <= 1'b1;
            r_remain <= '0;
            r_pcnt   <= '0;
        end else if (!w_phase_done) begin
            r_pcnt <= r_pcnt + 1'b1;
        end else begin
            r_pcnt <= '0;
            case (r_state)
                S_SETUP: begin
                    r_state <= S_STEP_LO;
                    r_step  <= 1'b0;
                end
                S_STEP_LO: begin
                    r_state <= S_STEP_HI;
                    r_step  <= 1'b1;
                end
                S_STEP_HI: begin
                    r_remain <= r_remain - 1'b1;
                    if (r_remain != LAST_STEP) begin
                        r_state <= S_STEP_LO;
                        r_step  <= 1'b0;
                    end else begin
                        r_state <= S_SETTLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // a set event in the same cycle as err_clear leaves the flag set
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err_lock <= 1'b0;
            r_err_bad  <= 1'b0;
        end else begin
            if (w_lock_lost) begin
                r_err_lock <= 1'b1;
            end else if (err_clear) begin
                r_err_lock <= 1'b0;
            end
            if (w_accept && w_bad_chan) begin
                r_err_bad <= 1'b1;
            end else if (err_clear) begin
                r_err_bad <= 1'b0;
            end
        end
    end

    assign cmd_ready       = (r_state == S_IDLE) && w_locked;
    assign phasesel        = r_sel;
    assign phasedir        = r_dir;
    assign phasestep       = r_step;
    assign phaseloadreg    = 1'b1;
    assign locked_stable   = w_locked;
    assign busy            = r_busy;
    assign err_lock_lost   = r_err_lock;
    assign err_bad_channel = r_err_bad;
endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// tb/tb_pll_dyn_ctrl.sv - directed table-driven bench for pll_dyn_ctrl
module tb_pll_dyn_ctrl;
    localparam int SW = 8;
    localparam int LF = 16;
    localparam int PC = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          pll_lock_in = 1'b0;
    logic          cmd_valid_a = 1'b0;
    logic          cmd_valid_b = 1'b0;
    logic [1:0]    cmd_channel = 2'd0;
    logic          cmd_dir = 1'b0;
    logic [SW-1:0] cmd_steps = '0;
    logic          err_clear = 1'b0;

    logic          a_cmd_ready, a_phasedir, a_phasestep, a_phaseloadreg;
    logic          a_locked, a_busy, a_err_lock, a_err_bad;
    logic [1:0]    a_phasesel;
    logic          b_cmd_ready, b_phasedir, b_phasestep, b_phaseloadreg;
    logic          b_locked, b_busy, b_err_lock, b_err_bad;
    logic [1:0]    b_phasesel;

    int checks = 0;
    int failures = 0;

    pll_dyn_ctrl #(.CHANNELS(4), .STEP_WIDTH(SW), .LOCK_FILTER(LF), .PULSE_CYCLES(PC)) dut_a (
        .clk(clk), .resetn(resetn), .pll_lock_in(pll_lock_in),
        .cmd_valid(cmd_valid_a), .cmd_ready(a_cmd_ready),
        .cmd_channel(cmd_channel), .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
        .phasesel(a_phasesel), .phasedir(a_phasedir), .phasestep(a_phasestep),
        .phaseloadreg(a_phaseloadreg), .locked_stable(a_locked), .busy(a_busy),
        .err_lock_lost(a_err_lock), .err_bad_channel(a_err_bad), .err_clear(err_clear)
    );

    pll_dyn_ctrl #(.CHANNELS(2), .STEP_WIDTH(SW), .LOCK_FILTER(LF), .PULSE_CYCLES(PC)) dut_b (
        .clk(clk), .resetn(resetn), .pll_lock_in(pll_lock_in),
        .cmd_valid(cmd_valid_b), .cmd_ready(b_cmd_ready),
        .cmd_channel(cmd_channel), .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
        .phasesel(b_phasesel), .phasedir(b_phasedir), .phasestep(b_phasestep),
        .phaseloadreg(b_phaseloadreg), .locked_stable(b_locked), .busy(b_busy),
        .err_lock_lost(b_err_lock), .err_bad_channel(b_err_bad), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]    ch;
        logic          dir;
        logic [SW-1:0] steps;
        int            exp_busy;
        int            exp_falls;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input int r, input vec_t v);
        int   busy_n, falls, bad_w, low_len, sel_err;
        logic prev;
        @(negedge clk);
        chk($sformatf("row%0d_ready_before", r), a_cmd_ready, 1);
        cmd_channel = v.ch;
        cmd_dir     = v.dir;
        cmd_steps   = v.steps;
        cmd_valid_a = 1'b1;
        @(negedge clk);
        cmd_valid_a = 1'b0;
        busy_n = 0; falls = 0; bad_w = 0; low_len = 0; sel_err = 0; prev = 1'b1;
        for (int i = 0; i < 5000 && a_busy; i++) begin
            busy_n++;
            if (a_phasesel !== v.ch || a_phasedir !== v.dir || a_phaseloadreg !== 1'b1) sel_err++;
            if (prev && !a_phasestep) falls++;
            if (!a_phasestep) begin
                low_len++;
            end else if (!prev) begin
                if (low_len != PC) bad_w++;
                low_len = 0;
            end
            prev = a_phasestep;
            @(negedge clk);
        end
        chk($sformatf("row%0d_busy_cycles", r), busy_n, v.exp_busy);
        chk($sformatf("row%0d_step_falls", r), falls, v.exp_falls);
        chk($sformatf("row%0d_low_width_errs", r), bad_w, 0);
        chk($sformatf("row%0d_sel_dir_errs", r), sel_err, 0);
        chk($sformatf("row%0d_ready_after", r), a_cmd_ready, 1);
        chk($sformatf("row%0d_step_idle", r), a_phasestep, 1);
        chk($sformatf("row%0d_err_bad", r), a_err_bad, 0);
        chk($sformatf("row%0d_err_lock", r), a_err_lock, 0);
    endtask

    initial begin
        int lows;
        vecs[0] = '{ch: 2'd2, dir: 1'b1, steps: 8'd3,   exp_busy: 32,   exp_falls: 3};
        vecs[1] = '{ch: 2'd0, dir: 1'b0, steps: 8'd1,   exp_busy: 16,   exp_falls: 1};
        vecs[2] = '{ch: 2'd1, dir: 1'b1, steps: 8'd0,   exp_busy: 0,    exp_falls: 0};
        vecs[3] = '{ch: 2'd3, dir: 1'b0, steps: 8'd2,   exp_busy: 24,   exp_falls: 2};
        vecs[4] = '{ch: 2'd1, dir: 1'b1, steps: 8'd255, exp_busy: 2048, exp_falls: 255};

        // reset values, with lock held high to show the synchroniser is held too
        pll_lock_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_locked", a_locked, 0);
        chk("rst_ready", a_cmd_ready, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_step", a_phasestep, 1);
        chk("rst_loadreg", a_phaseloadreg, 1);
        chk("rst_dir", a_phasedir, 1);
        chk("rst_sel", a_phasesel, 0);
        chk("rst_err_lock", a_err_lock, 0);
        chk("rst_err_bad", a_err_bad, 0);
        chk("rst_b_step", b_phasestep, 1);

        // lock glitch once the filter count reaches 10: count restarts
        pll_lock_in = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        pll_lock_in = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            if (k == 12) pll_lock_in = 1'b0;
            if (k == 13) pll_lock_in = 1'b1;
            if (k == 18) chk("glitch_no_early_lock", a_locked, 0);
            if (k == 30) chk("glitch_lock_k30", a_locked, 0);
            if (k == 31) chk("glitch_lock_k31", a_locked, 1);
        end

        for (int r = 0; r < 5; r++) run_vec(r, vecs[r]);

        // lock lost during 2nd of 5 steps
        @(negedge clk);
        cmd_channel = 2'd1; cmd_dir = 1'b0; cmd_steps = 8'd5; cmd_valid_a = 1'b1;
        @(negedge clk);
        cmd_valid_a = 1'b0;
        repeat (12) @(negedge clk);
        pll_lock_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("drop_locked_a14", a_locked, 1);
        @(negedge clk);
        chk("drop_locked_a15", a_locked, 0);
        chk("drop_busy_a15", a_busy, 1);
        chk("drop_step_a15", a_phasestep, 0);
        chk("drop_err_a15", a_err_lock, 0);
        @(negedge clk);
        chk("drop_busy_a16", a_busy, 0);
        chk("drop_step_a16", a_phasestep, 1);
        chk("drop_err_a16", a_err_lock, 1);
        chk("drop_ready_a16", a_cmd_ready, 0);
        repeat (4) @(negedge clk);
        chk("drop_ready_unlocked", a_cmd_ready, 0);
        pll_lock_in = 1'b1;
        repeat (17) @(negedge clk);
        chk("relock_locked_17", a_locked, 0);
        chk("relock_ready_17", a_cmd_ready, 0);
        @(negedge clk);
        chk("relock_locked_18", a_locked, 1);
        chk("relock_ready_18", a_cmd_ready, 1);
        chk("relock_err_sticky", a_err_lock, 1);

        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("clear_err_lock", a_err_lock, 0);

        // bad channel on the 2-channel instance
        chk("bad_ready_before", b_cmd_ready, 1);
        cmd_channel = 2'd3; cmd_dir = 1'b1; cmd_steps = 8'd2; cmd_valid_b = 1'b1;
        @(negedge clk);
        cmd_valid_b = 1'b0;
        chk("bad_err_set", b_err_bad, 1);
        chk("bad_busy", b_busy, 0);
        chk("bad_ready_next", b_cmd_ready, 1);
        chk("bad_err_lock", b_err_lock, 0);
        lows = 0;
        for (int k = 0; k < 12; k++) begin
            if (!b_phasestep || b_busy) lows++;
            @(negedge clk);
        end
        chk("bad_no_pulses", lows, 0);

        // err_clear in the same cycle as a new bad command: set wins
        cmd_channel = 2'd2; cmd_steps = 8'd1; cmd_valid_b = 1'b1; err_clear = 1'b1;
        @(negedge clk);
        cmd_valid_b = 1'b0; err_clear = 1'b0;
        chk("clear_vs_set", b_err_bad, 1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("clear_err_bad", b_err_bad, 0);

        // asynchronous reset in STEP_LO
        cmd_channel = 2'd2; cmd_dir = 1'b1; cmd_steps = 8'd3; cmd_valid_a = 1'b1;
        @(negedge clk);
        cmd_valid_a = 1'b0;
        repeat (5) @(negedge clk);
        chk("arst_pre_step", a_phasestep, 0);
        #2 resetn = 1'b0;
        #1;
        chk("arst_step", a_phasestep, 1);
        chk("arst_busy", a_busy, 0);
        chk("arst_ready", a_cmd_ready, 0);
        chk("arst_locked", a_locked, 0);
        chk("arst_sel", a_phasesel, 0);
        chk("arst_dir", a_phasedir, 1);
        chk("arst_loadreg", a_phaseloadreg, 1);
        chk("arst_err_lock", a_err_lock, 0);
        chk("arst_err_bad", a_err_bad, 0);
        lows = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!a_phasestep || a_busy) lows++;
        end
        chk("arst_no_pulses", lows, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
